ddr4_avmm_burst_responder: RTL

//  Avalon-MM burst slave emulating one local DDR4 bank (responder end of DDR4a/DDR4b).

---
 rtl/ddr4_avmm_burst_responder.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/ddr4_avmm_burst_responder.sv
// ddr4_avmm_burst_responder
// Avalon-MM burst slave standing in for one local DDR4 bank. Write bursts land
// in an on-chip RAM under byteenable; read bursts are issued one beat per cycle
// into a fixed-latency pipe. Optional periodic waitrequest injection exercises
// master backpressure. Protocol misuse is flagged in a sticky error bit.
module ddr4_avmm_burst_responder #(
    parameter int DATA_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 26,
    parameter int BURST_WIDTH    = 7,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int READ_LATENCY   = 4,
    parameter int STALL_EVERY    = 0
) (
    input  logic                      DDR4_USERCLK,
    input  logic                      SoftReset,
    input  logic [ADDR_WIDTH-1:0]     DDR4_address,
    input  logic [BURST_WIDTH-1:0]    DDR4_burstcount,
    input  logic                      DDR4_read,
    input  logic                      DDR4_write,
    input  logic [DATA_WIDTH-1:0]     DDR4_writedata,
    input  logic [DATA_WIDTH/8-1:0]   DDR4_byteenable,
    output logic                      DDR4_waitrequest,
    output logic [DATA_WIDTH-1:0]     DDR4_readdata,
    output logic                      DDR4_readdatavalid,
    output logic                      err_sticky,
    output logic [31:0]               wr_beats,
    output logic [31:0]               rd_beats
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << MEM_DEPTH_LOG2;
    localparam int MAX_BURST = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    state_t                    state_r, state_s;
    logic [BURST_WIDTH-1:0]    remaining_r, remaining_s;
    logic [MEM_DEPTH_LOG2-1:0] idx_r, idx_s;
    logic [31:0]               stall_cnt_r;
    logic                      stall_s;
    logic                      waitrequest_s;
    logic                      accept_s;
    logic                      burst_bad_s;
    logic [BURST_WIDTH-1:0]    burst_eff_s;
    logic [MEM_DEPTH_LOG2-1:0] addr_idx_s;
    logic                      mem_we_s;
    logic [MEM_DEPTH_LOG2-1:0] mem_widx_s;
    logic                      issue_s;
    logic                      err_set_s;
    logic                      err_r;
    logic [31:0]               wr_beats_r;
    logic [31:0]               rd_beats_r;
    logic [READ_LATENCY-1:0]   valid_pipe_r;
    logic [READ_LATENCY:0]     valid_ext_s;
    logic [DATA_WIDTH-1:0]     data_pipe_r [READ_LATENCY];
    logic [DATA_WIDTH-1:0]     mem [DEPTH];
    logic                      addr_unused_s;

    // Only the low address bits select a RAM line; the rest alias silently.
    assign addr_unused_s = ^DDR4_address;
    assign addr_idx_s    = DDR4_address[MEM_DEPTH_LOG2-1:0];

    // Stall injection decode: one forced-busy cycle per STALL_EVERY cycles.
    always_comb begin
        stall_s = 1'b0;
        if ((STALL_EVERY > 0) && (stall_cnt_r == 32'(STALL_EVERY - 1))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Out-of-range burst lengths are flagged and degraded to a single beat.
    always_comb begin
        burst_bad_s = 1'b0;
        burst_eff_s = DDR4_burstcount;
        if ((DDR4_burstcount == BURST_WIDTH'(0)) ||
            (DDR4_burstcount > BURST_WIDTH'(MAX_BURST))) begin
            burst_bad_s = 1'b1;
            burst_eff_s = BURST_WIDTH'(1);
        end else begin
            burst_bad_s = 1'b0;
            burst_eff_s = DDR4_burstcount;
        end
    end

    // Busy while in reset, while issuing a read burst, or on an injected stall.
    assign waitrequest_s = SoftReset | (state_r == ST_RD) | stall_s;
    assign accept_s      = (DDR4_read | DDR4_write) & ~waitrequest_s;
    assign valid_ext_s   = {valid_pipe_r, issue_s};

    // Next-state logic and per-cycle RAM write / read-issue controls.
    always_comb begin
        state_s     = state_r;
        remaining_s = remaining_r;
        idx_s       = idx_r;
        mem_we_s    = 1'b0;
        mem_widx_s  = idx_r;
        issue_s     = 1'b0;
        err_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (DDR4_write) begin
                        // A simultaneous read is a violation and is dropped.
                        mem_we_s   = 1'b1;
                        mem_widx_s = addr_idx_s;
                        err_set_s  = DDR4_read | burst_bad_s;
                        if (burst_eff_s > BURST_WIDTH'(1)) begin
                            state_s     = ST_WR;
                            remaining_s = burst_eff_s - BURST_WIDTH'(1);
                            idx_s       = addr_idx_s + MEM_DEPTH_LOG2'(1);
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        err_set_s   = burst_bad_s;
                        state_s     = ST_RD;
                        remaining_s = burst_eff_s;
                        idx_s       = addr_idx_s;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR: begin
                if (accept_s) begin
                    err_set_s = DDR4_read;
                    if (DDR4_write) begin
                        mem_we_s    = 1'b1;
                        mem_widx_s  = idx_r;
                        idx_s       = idx_r + MEM_DEPTH_LOG2'(1);
                        remaining_s = remaining_r - BURST_WIDTH'(1);
                        if (remaining_r == BURST_WIDTH'(1)) begin
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_WR;
                        end
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end else begin
                    state_s = ST_WR;
                end
            end
            ST_RD: begin
                // One beat per cycle, never stalled.
                issue_s     = 1'b1;
                idx_s       = idx_r + MEM_DEPTH_LOG2'(1);
                remaining_s = remaining_r - BURST_WIDTH'(1);
                if (remaining_r == BURST_WIDTH'(1)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Free-running stall phase counter, restarted by reset.
    always_ff @(posedge DDR4_USERCLK) begin
        if (SoftReset) begin
            stall_cnt_r <= 32'd0;
        end else if ((STALL_EVERY == 0) || stall_s) begin
            stall_cnt_r <= 32'd0;
        end else begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    // Backing RAM write port with per-byte enables; contents survive reset.
    always_ff @(posedge DDR4_USERCLK) begin
        if (mem_we_s) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (DDR4_byteenable[b]) begin
                    mem[mem_widx_s][b*8 +: 8] <= DDR4_writedata[b*8 +: 8];
                end
            end
        end
    end

    // FSM state, read latency pipe, sticky error and beat counters.
    always_ff @(posedge DDR4_USERCLK) begin
        if (SoftReset) begin
            state_r      <= ST_IDLE;
            remaining_r  <= '0;
            idx_r        <= '0;
            err_r        <= 1'b0;
            wr_beats_r   <= 32'd0;
            rd_beats_r   <= 32'd0;
            valid_pipe_r <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_pipe_r[i] <= '0;
            end
        end else begin
            state_r      <= state_s;
            remaining_r  <= remaining_s;
            idx_r        <= idx_s;
            err_r        <= err_r | err_set_s;
            wr_beats_r   <= wr_beats_r + (mem_we_s ? 32'd1 : 32'd0);
            rd_beats_r   <= rd_beats_r + (valid_ext_s[READ_LATENCY-1] ? 32'd1 : 32'd0);
            valid_pipe_r <= valid_ext_s[READ_LATENCY-1:0];
            data_pipe_r[0] <= mem[idx_r];
            for (int i = 1; i < READ_LATENCY; i++) begin
                data_pipe_r[i] <= data_pipe_r[i-1];
            end
        end
    end

    assign DDR4_waitrequest   = waitrequest_s;
    assign DDR4_readdata      = data_pipe_r[READ_LATENCY-1];
    assign DDR4_readdatavalid = valid_pipe_r[READ_LATENCY-1];
    assign err_sticky         = err_r;
    assign wr_beats           = wr_beats_r;
    assign rd_beats           = rd_beats_r;

endmodule
